// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard unit for a 5-stage MIPS pipeline.
//   Keeps a shadow scoreboard of in-flight writers in E/M/W.
//   It drives the global stall and every forwarding select.
//
//   Config macro HAZ_FWD_EN:
//     defined   : Tuse/Tnew stall with forwarding.
//     undefined : full interlock; all forwarding selects are tied to 0.
//
//   Ports:
//     clk, rst_n                    clock, async active-low reset
//     rs_d, rt_d                    D-stage source registers
//     tuse_rs_d, tuse_rt_d          Tuse per operand (TUSE_NONE = not read)
//     a3_d, rfwe_d, tnew_d          D-stage destination, write enable, Tnew at E entry
//     stall                         hold PC and F/D, bubble D/E
//     fwd_rs_d, fwd_rt_d            0 RF, 1 E, 2 M, 3 W
//     fwd_rs_e, fwd_rt_e            0 D/E reg, 1 M, 2 W
//     fwd_rt_m                      0 E/M reg, 1 W
//     stall_cnt                     saturating count of stall cycles
module hazard_scoreboard #(
  parameter logic [2:0] TUSE_NONE = 3'd4,
  parameter int         CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [2:0]       tuse_rs_d,
  input  logic [2:0]       tuse_rt_d,
  input  logic [4:0]       a3_d,
  input  logic             rfwe_d,
  input  logic [2:0]       tnew_d,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic             fwd_rt_m,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  // Only the fields each stage actually consumes are stored.
  // M keeps rt for the store-data forward.
  // W keeps no tnew, because tnew has always decayed to 0 by then.
  logic             r_e_we, r_m_we, r_w_we;
  logic [4:0]       r_e_a3, r_e_rs, r_e_rt, r_m_a3, r_m_rt, r_w_a3;
  logic [2:0]       r_e_tnew, r_m_tnew;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_rs_used, w_rt_used, w_stall_rs, w_stall_rt;
  function automatic logic f_match(input logic we, input logic [4:0] a3, input logic [4:0] r);
    return we && a3 == r && r != 5'd0;
  endfunction
  function automatic logic [2:0] f_dec(input logic [2:0] x);
    return (x == 3'd0) ? 3'd0 : x - 3'd1;
  endfunction
  assign w_rs_used = tuse_rs_d != TUSE_NONE;
  assign w_rt_used = tuse_rt_d != TUSE_NONE;
`ifdef HAZ_FWD_EN
  assign w_stall_rs = w_rs_used &&
    ((f_match(r_e_we, r_e_a3, rs_d) && r_e_tnew > tuse_rs_d) ||
     (f_match(r_m_we, r_m_a3, rs_d) && r_m_tnew > tuse_rs_d));
  assign w_stall_rt = w_rt_used &&
    ((f_match(r_e_we, r_e_a3, rt_d) && r_e_tnew > tuse_rt_d) ||
     (f_match(r_m_we, r_m_a3, rt_d) && r_m_tnew > tuse_rt_d));
  // Youngest producer whose result is ready wins.
  always_comb begin
    fwd_rs_d = (f_match(r_e_we, r_e_a3, rs_d) && r_e_tnew == 3'd0) ? 2'd1 :
               (f_match(r_m_we, r_m_a3, rs_d) && r_m_tnew == 3'd0) ? 2'd2 :
               f_match(r_w_we, r_w_a3, rs_d) ? 2'd3 : 2'd0;
    fwd_rt_d = (f_match(r_e_we, r_e_a3, rt_d) && r_e_tnew == 3'd0) ? 2'd1 :
               (f_match(r_m_we, r_m_a3, rt_d) && r_m_tnew == 3'd0) ? 2'd2 :
               f_match(r_w_we, r_w_a3, rt_d) ? 2'd3 : 2'd0;
    fwd_rs_e = (f_match(r_m_we, r_m_a3, r_e_rs) && r_m_tnew == 3'd0) ? 2'd1 :
               f_match(r_w_we, r_w_a3, r_e_rs) ? 2'd2 : 2'd0;
    fwd_rt_e = (f_match(r_m_we, r_m_a3, r_e_rt) && r_m_tnew == 3'd0) ? 2'd1 :
               f_match(r_w_we, r_w_a3, r_e_rt) ? 2'd2 : 2'd0;
    fwd_rt_m = f_match(r_w_we, r_w_a3, r_m_rt);
  end
`else
  logic w_unused;
  // Entry fields are still tracked but only read by the forwarding network.
  assign w_unused   = ^{r_m_tnew, r_e_rs, r_m_rt};
  assign w_stall_rs = w_rs_used &&
    (f_match(r_e_we, r_e_a3, rs_d) || f_match(r_m_we, r_m_a3, rs_d) || f_match(r_w_we, r_w_a3, rs_d));
  assign w_stall_rt = w_rt_used &&
    (f_match(r_e_we, r_e_a3, rt_d) || f_match(r_m_we, r_m_a3, rt_d) || f_match(r_w_we, r_w_a3, rt_d));
  assign fwd_rs_d = 2'd0;
  assign fwd_rt_d = 2'd0;
  assign fwd_rs_e = 2'd0;
  assign fwd_rt_e = 2'd0;
  assign fwd_rt_m = 1'b0;
`endif
  assign stall     = w_stall_rs | w_stall_rt;
  assign stall_cnt = r_stall_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_we      <= 1'b0;
      r_e_a3      <= '0;
      r_e_tnew    <= '0;
      r_e_rs      <= '0;
      r_e_rt      <= '0;
      r_m_we      <= 1'b0;
      r_m_a3      <= '0;
      r_m_tnew    <= '0;
      r_m_rt      <= '0;
      r_w_we      <= 1'b0;
      r_w_a3      <= '0;
      r_stall_cnt <= '0;
    end else begin
      // On a stall the D instruction is held and a bubble (all-zero entry) goes to E.
      r_e_we      <= !stall && rfwe_d && a3_d != 5'd0;
      r_e_a3      <= stall ? 5'd0 : a3_d;
      r_e_tnew    <= stall ? 3'd0 : tnew_d;
      r_e_rs      <= stall ? 5'd0 : rs_d;
      r_e_rt      <= stall ? 5'd0 : rt_d;
      r_m_we      <= r_e_we;
      r_m_a3      <= r_e_a3;
      r_m_tnew    <= f_dec(r_e_tnew);
      r_m_rt      <= r_e_rt;
      r_w_we      <= r_m_we;
      r_w_a3      <= r_m_a3;
      r_stall_cnt <= (stall && !(&r_stall_cnt)) ? r_stall_cnt + CNT_ONE : r_stall_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random instruction stream checked against a stage-slot model.
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs_d = '0, rt_d = '0, a3_d = '0;
  logic [2:0]  tuse_rs_d = 3'd4, tuse_rt_d = 3'd4, tnew_d = '0;
  logic        rfwe_d = 1'b0;
  logic        stall, fwd_rt_m;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic [31:0] stall_cnt;
  int n_vec = 0, n_err = 0;
  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .a3_d(a3_d),
    .rfwe_d(rfwe_d), .tnew_d(tnew_d), .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  // Model: slot k = instruction k+1 cycles past decode (0=E,1=M,2=W).
  // Ready-ness derives from age: remaining tnew = max(t0 - k, 0).
  logic       m_wr[3];
  logic [4:0] m_a3[3], m_rs[3], m_rt[3];
  int         m_t0[3];
  int         m_cnt;
  logic       e_stall, e_frtm;
  logic [1:0] e_frsd, e_frtd, e_frse, e_frte;
  logic       s_stall, s_frtm;
  logic [1:0] s_frsd, s_frtd, s_frse, s_frte;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int rem(input int k);
    return (m_t0[k] > k) ? m_t0[k] - k : 0;
  endfunction
  function automatic logic hit(input int k, input logic [4:0] r);
    return m_wr[k] && m_a3[k] == r && r != 5'd0;
  endfunction
  function automatic logic [1:0] src(input logic [4:0] r, input int first);
    for (int k = first; k < 3; k++)
      if (hit(k, r) && rem(k) == 0) return 2'(k + 1 - first);
    return 2'd0;
  endfunction
  function automatic logic op_stall(input logic [4:0] r, input logic [2:0] tu);
    if (tu == 3'd4) return 1'b0;
`ifdef HAZ_FWD_EN
    for (int k = 0; k < 2; k++) if (hit(k, r) && rem(k) > int'(tu)) return 1'b1;
`else
    for (int k = 0; k < 3; k++) if (hit(k, r)) return 1'b1;
`endif
    return 1'b0;
  endfunction
  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_wr[k] = 0; m_a3[k] = 0; m_rs[k] = 0; m_rt[k] = 0; m_t0[k] = 0;
    end
    m_cnt = 0;
  endtask
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] tur,
                      input logic [2:0] tut, input logic [4:0] a3, input logic we,
                      input logic [2:0] tn, output logic st);
    @(negedge clk);
    rs_d = rs; rt_d = rt; tuse_rs_d = tur; tuse_rt_d = tut; a3_d = a3; rfwe_d = we; tnew_d = tn;
    #1;
    e_stall = op_stall(rs, tur) | op_stall(rt, tut);
`ifdef HAZ_FWD_EN
    e_frsd = src(rs, 0); e_frtd = src(rt, 0);
    e_frse = src(m_rs[0], 1); e_frte = src(m_rt[0], 1);
    e_frtm = hit(2, m_rt[1]);
`else
    e_frsd = 0; e_frtd = 0; e_frse = 0; e_frte = 0; e_frtm = 0;
`endif
    chk("stall", stall, e_stall);
    chk("fwd_rs_d", fwd_rs_d, e_frsd);
    chk("fwd_rt_d", fwd_rt_d, e_frtd);
    chk("fwd_rs_e", fwd_rs_e, e_frse);
    chk("fwd_rt_e", fwd_rt_e, e_frte);
    chk("fwd_rt_m", fwd_rt_m, e_frtm);
    chk("stall_cnt", stall_cnt, m_cnt);
    s_stall = stall; s_frsd = fwd_rs_d; s_frtd = fwd_rt_d;
    s_frse = fwd_rs_e; s_frte = fwd_rt_e; s_frtm = fwd_rt_m;
    st = e_stall;
    @(posedge clk);
    for (int k = 2; k > 0; k--) begin
      m_wr[k] = m_wr[k-1]; m_a3[k] = m_a3[k-1]; m_rs[k] = m_rs[k-1];
      m_rt[k] = m_rt[k-1]; m_t0[k] = m_t0[k-1];
    end
    m_wr[0] = !e_stall && we && a3 != 0;
    m_a3[0] = e_stall ? 5'd0 : a3;
    m_rs[0] = e_stall ? 5'd0 : rs;
    m_rt[0] = e_stall ? 5'd0 : rt;
    m_t0[0] = e_stall ? 0 : int'(tn);
    if (e_stall) m_cnt++;
  endtask
  // Presents one instruction, holding it in D while stalled; returns stall cycles.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [2:0] tur,
                       input logic [2:0] tut, input logic [4:0] a3, input logic we,
                       input logic [2:0] tn, output int n);
    logic st;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(rs, rt, tur, tut, a3, we, tn, st);
      if (!st) return;
      n++;
    end
    chk("hold_timeout", st, 1'b0);
  endtask
  task automatic nops(input int k);
    int n;
    for (int i = 0; i < k; i++) issue(0, 0, 3'd4, 3'd4, 0, 1'b0, 3'd0, n);
  endtask
  int n, c0;
  initial begin
    model_clear();
    #12;
    chk("rst_stall", stall, 1'b0);
    chk("rst_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}, 0);
    chk("rst_cnt", stall_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    // lw $1 then addu $2,$1,$3
    issue(0, 0, 3'd4, 3'd4, 5'd1, 1'b1, 3'd2, n);
    c0 = m_cnt;
    issue(5'd1, 5'd3, 3'd1, 3'd1, 5'd2, 1'b1, 3'd1, n);
`ifdef HAZ_FWD_EN
    chk("t1_stalls", n, 1);
`else
    chk("t1_stalls", n, 3);
`endif
    chk("t1_cnt", stall_cnt - c0, n);
    nops(1);
`ifdef HAZ_FWD_EN
    chk("t1_fwd_rs_e", s_frse, 2);
`else
    chk("t1_fwd_rs_e", s_frse, 0);
`endif
    nops(3);
    // lw $1 then beq $1,$0
    issue(0, 0, 3'd4, 3'd4, 5'd1, 1'b1, 3'd2, n);
    issue(5'd1, 5'd0, 3'd0, 3'd0, 5'd0, 1'b0, 3'd0, n);
`ifdef HAZ_FWD_EN
    chk("t2_stalls", n, 2);
    chk("t2_fwd_rs_d", s_frsd, 3);
`else
    chk("t2_stalls", n, 3);
    chk("t2_fwd_rs_d", s_frsd, 0);
`endif
    nops(3);
    // addu $1 then sw $1,0($2)
    issue(0, 0, 3'd1, 3'd1, 5'd1, 1'b1, 3'd1, n);
    issue(5'd2, 5'd1, 3'd1, 3'd2, 5'd0, 1'b0, 3'd0, n);
    nops(1);
`ifdef HAZ_FWD_EN
    chk("t3_stalls", n, 0);
    chk("t3_fwd_rt_e", s_frte, 1);
    nops(1);
    chk("t3_fwd_rt_m", s_frtm, 1);
`else
    chk("t3_stalls", n, 3);
    chk("t3_fwd_rt_e", s_frte, 0);
    nops(1);
    chk("t3_fwd_rt_m", s_frtm, 0);
`endif
    nops(3);
    // ori $0,$0,5 then addu $2,$0,$0
    issue(5'd0, 5'd0, 3'd1, 3'd4, 5'd0, 1'b1, 3'd1, n);
    issue(5'd0, 5'd0, 3'd1, 3'd1, 5'd2, 1'b1, 3'd1, n);
    chk("t4_stalls", n, 0);
    chk("t4_fwd", {s_frsd, s_frtd}, 0);
    nops(3);
    // reset asserted during a stall cycle
    issue(0, 0, 3'd4, 3'd4, 5'd1, 1'b1, 3'd2, n);
    @(negedge clk);
    rs_d = 5'd1; rt_d = 5'd3; tuse_rs_d = 3'd1; tuse_rt_d = 3'd1; a3_d = 5'd2; rfwe_d = 1'b1; tnew_d = 3'd1;
    #1;
    chk("t5_pre_stall", stall, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_stall", stall, 1'b0);
    chk("t5_cnt", stall_cnt, 0);
    chk("t5_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}, 0);
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    issue(5'd1, 5'd3, 3'd1, 3'd1, 5'd2, 1'b1, 3'd1, n);
    chk("t5_after_stalls", n, 0);
    nops(3);
    // random instruction stream over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [2:0] tur, tut;
      tur = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 2));
      tut = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 2));
      issue(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), tur, tut,
            5'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 2)), n);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
